// File: rtl/pps_sync_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pps_sync_ctrl_pkg
// Shared definitions for the PPS frame-sync controller: controller state
// encoding, default period/tolerance values and a period-window helper.
// -----------------------------------------------------------------------------
package pps_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

  localparam int unsigned DEF_FREQ     = 30720000;
  localparam int unsigned DEF_PPS_TOL  = 64;
  localparam int unsigned DEF_LOCK_CNT = 3;
  localparam int unsigned DEF_HOLD_MAX = 4;

  // Inclusive window test used to classify a measured PPS period.
  function automatic logic in_window(input logic [31:0] cnt,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/pps_sync_ctrl_edge_det.sv
// -----------------------------------------------------------------------------
// pps_edge_det
// Brings the asynchronous 1PPS input into the clk domain through a 2-flop
// synchronizer and emits a registered one-cycle pulse on each rising edge.
// The pulse is high in the third cycle after the cycle in which pps_i rose.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   pps_i      in   asynchronous 1PPS
//   pps_edge_o out  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module pps_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic pps_i,
  output logic pps_edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pps_i};
      prev_q <= sync_q[1];
      edge_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pps_edge_o = edge_q;

endmodule

// File: rtl/pps_sync_ctrl.sv
// -----------------------------------------------------------------------------
// pps_sync_ctrl
// Qualifies a 1PPS reference against the expected period, locks after
// LOCK_CNT consecutive good periods, flywheels through up to HOLD_MAX missed
// pulses and issues a single sync_start pulse to the frame-sync counter on
// every ACQUIRE->LOCKED transition.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   pps_in      in   asynchronous 1PPS from GNSS/PTP
//   enable      in   level; 0 forces IDLE on the next cycle
//   delay_cfg   in   [31:0] PPS-to-frame offset, sampled only at lock
//   sync_start  out  one-cycle pulse on ACQUIRE->LOCKED
//   delay       out  [31:0] delay_cfg captured at lock
//   sync_enable out  high in LOCKED or HOLDOVER
//   pps_period  out  [31:0] last measured edge-to-edge period
//   pps_err     out  one-cycle pulse on bad period or holdover expiry
//   state       out  [1:0] controller state (IDLE/ACQUIRE/LOCKED/HOLDOVER)
//
// sync_start and pps_err are combinational pulses, high during the same
// cycle as the qualifying PPS edge (or overrun) that triggers them.
// -----------------------------------------------------------------------------
module pps_sync_ctrl
  import pps_sync_ctrl_pkg::*;
#(
  parameter int unsigned FREQ     = DEF_FREQ,
  parameter int unsigned PPS_TOL  = DEF_PPS_TOL,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pps_in,
  input  logic        enable,
  input  logic [31:0] delay_cfg,
  output logic        sync_start,
  output logic [31:0] delay,
  output logic        sync_enable,
  output logic [31:0] pps_period,
  output logic        pps_err,
  output logic [1:0]  state
);

  localparam logic [31:0] WIN_LO = 32'(FREQ - PPS_TOL);
  localparam logic [31:0] WIN_HI = 32'(FREQ + PPS_TOL);
  localparam logic [31:0] FREQ_W = 32'(FREQ);

  pps_state_e  state_q, state_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] pps_period_q, pps_period_d;
  logic [31:0] delay_q, delay_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        first_seen_q, first_seen_d;
  logic        sync_start_c, pps_err_c;

  logic        pps_edge;
  logic        period_good;
  logic        overrun;
  logic [31:0] cnt_inc;
  logic [31:0] cnt_rebased;

  pps_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .pps_i      (pps_in),
    .pps_edge_o (pps_edge)
  );

  assign cnt_inc     = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 32'd1;
  assign period_good = in_window(period_cnt_q, WIN_LO, WIN_HI);
  assign overrun     = period_cnt_q > WIN_HI;
  // Re-reference the count to the virtual edge that was due FREQ cycles in,
  // so the flywheel keeps the original cadence while no pulse arrives.
  assign cnt_rebased = period_cnt_q - FREQ_W + 32'd1;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = pps_edge ? 32'd1 : cnt_inc;
    pps_period_d = pps_edge ? period_cnt_q : pps_period_q;
    delay_d      = delay_q;
    good_cnt_d   = good_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    first_seen_d = first_seen_q;
    sync_start_c = 1'b0;
    pps_err_c    = 1'b0;

    if (!enable) begin
      // Disable wins over any edge arriving in the same cycle.
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      pps_period_d = pps_period_q;
      good_cnt_d   = '0;
      miss_cnt_d   = '0;
      first_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          period_cnt_d = '0;
          pps_period_d = pps_period_q;
          good_cnt_d   = '0;
          miss_cnt_d   = '0;
          first_seen_d = 1'b0;
          state_d      = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          if (pps_edge) begin
            if (!first_seen_q) begin
              first_seen_d = 1'b1;
            end else if (period_good) begin
              if (good_cnt_q + 16'd1 >= 16'(LOCK_CNT)) begin
                state_d      = ST_LOCKED;
                good_cnt_d   = '0;
                delay_d      = delay_cfg;
                sync_start_c = 1'b1;
              end else begin
                good_cnt_d = good_cnt_q + 16'd1;
              end
            end else begin
              good_cnt_d = '0;
              pps_err_c  = 1'b1;
            end
          end else if (overrun) begin
            good_cnt_d   = '0;
            first_seen_d = 1'b0;
          end
        end

        ST_LOCKED: begin
          if (pps_edge) begin
            if (!period_good) begin
              pps_err_c    = 1'b1;
              state_d      = ST_ACQUIRE;
              good_cnt_d   = '0;
              first_seen_d = 1'b1;
            end
          end else if (overrun) begin
            state_d      = ST_HOLDOVER;
            miss_cnt_d   = 16'd1;
            period_cnt_d = cnt_rebased;
          end
        end

        ST_HOLDOVER: begin
          if (pps_edge) begin
            miss_cnt_d = '0;
            if (period_good) begin
              state_d = ST_LOCKED;
            end else begin
              pps_err_c    = 1'b1;
              state_d      = ST_ACQUIRE;
              good_cnt_d   = '0;
              first_seen_d = 1'b1;
            end
          end else if (overrun) begin
            if (miss_cnt_q + 16'd1 >= 16'(HOLD_MAX)) begin
              pps_err_c    = 1'b1;
              state_d      = ST_ACQUIRE;
              miss_cnt_d   = '0;
              good_cnt_d   = '0;
              first_seen_d = 1'b0;
            end else begin
              miss_cnt_d   = miss_cnt_q + 16'd1;
              period_cnt_d = cnt_rebased;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      pps_period_q <= '0;
      delay_q      <= '0;
      good_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      first_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      pps_period_q <= pps_period_d;
      delay_q      <= delay_d;
      good_cnt_q   <= good_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign sync_start  = sync_start_c;
  assign pps_err     = pps_err_c;
  assign delay       = delay_q;
  assign pps_period  = pps_period_q;
  assign sync_enable = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
  assign state       = state_q;

endmodule

// File: tb/tb_pps_sync_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pps_sync_ctrl
// Directed PPS scenarios with FREQ=1000, PPS_TOL=4, LOCK_CNT=3, HOLD_MAX=2.
// Expected sync_start / pps_err pulses are queued with their cycle when the
// PPS rise is driven; a monitor pops and compares them as the DUT pulses.
// -----------------------------------------------------------------------------
module tb_pps_sync_ctrl;

  localparam int W = 34;
  localparam logic [1:0] EVT_SS  = 2'd1;
  localparam logic [1:0] EVT_ERR = 2'd2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pps_in;
  logic        enable;
  logic [31:0] delay_cfg;
  logic        sync_start;
  logic [31:0] delay;
  logic        sync_enable;
  logic [31:0] pps_period;
  logic        pps_err;
  logic [1:0]  state;

  int cyc = 0;
  int last_rise = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pps_sync_ctrl #(
    .FREQ     (1000),
    .PPS_TOL  (4),
    .LOCK_CNT (3),
    .HOLD_MAX (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pps_in      (pps_in),
    .enable      (enable),
    .delay_cfg   (delay_cfg),
    .sync_start  (sync_start),
    .delay       (delay),
    .sync_enable (sync_enable),
    .pps_period  (pps_period),
    .pps_err     (pps_err),
    .state       (state)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic score_evt(input logic [1:0] kind);
    logic [W-1:0] got;
    logic [W-1:0] want;
    got = {kind, 32'(cyc)};
    if (exp_q.size() == 0) begin
      check_eq("evt_unexpected", 64'(got), 64'd0);
    end else begin
      want = exp_q.pop_front();
      check_eq("evt", 64'(got), 64'(want));
    end
  endtask

  // Scoreboard consumer: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (sync_start) score_evt(EVT_SS);
    if (pps_err)    score_evt(EVT_ERR);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    if (cyc > c) check_eq("schedule", 64'(cyc), 64'(c));
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_at(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  task automatic pps_low();
    while (pps_in && (cyc < last_rise + 50)) begin
      @(posedge clk);
      #1;
    end
    pps_in = 1'b0;
  endtask

  // Rise at absolute cycle t; the DUT edge pulse lands in cycle t+3.
  task automatic pps_rise_at(input int t, input logic [1:0] kind);
    pps_low();
    wait_cyc(t);
    pps_in    = 1'b1;
    last_rise = t;
    if (kind != 2'd0) exp_q.push_back({kind, 32'(t + 3)});
  endtask

  task automatic pps_rise(input int gap, input logic [1:0] kind);
    pps_rise_at(last_rise + gap, kind);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"},       64'(state),       64'd0);
    check_eq({tag, "_sync_start"},  64'(sync_start),  64'd0);
    check_eq({tag, "_sync_enable"}, 64'(sync_enable), 64'd0);
    check_eq({tag, "_pps_err"},     64'(pps_err),     64'd0);
    check_eq({tag, "_delay"},       64'(delay),       64'd0);
    check_eq({tag, "_pps_period"},  64'(pps_period),  64'd0);
  endtask

  // ---------------- stimulus ----------------
  int e;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    pps_in    = 1'b0;
    delay_cfg = 32'h0;
    check_at(3);
    check_all_zero("reset");
    enable    = 1'b1;
    delay_cfg = 32'h0000_1234;
    wait_cyc(5);
    rst_n = 1'b1;

    // Nominal lock: first edge arms, three good periods lock on the 4th.
    pps_rise_at(100, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("lock_state",  64'(state),       64'd2);
    check_eq("lock_delay",  64'(delay),       64'h1234);
    check_eq("lock_syncen", 64'(sync_enable), 64'd1);
    check_eq("lock_period", 64'(pps_period),  64'd1000);
    delay_cfg = 32'h0000_5678;

    // Window boundaries while locked.
    pps_rise(996, 2'd0);
    pps_rise(1004, 2'd0);
    check_at(last_rise + 4);
    check_eq("b1004_state",  64'(state),      64'd2);
    check_eq("b1004_period", 64'(pps_period), 64'd1004);
    check_eq("b1004_delay",  64'(delay),      64'h1234);
    pps_rise(995, EVT_ERR);
    check_at(last_rise + 4);
    check_eq("b995_state", 64'(state), 64'd1);
    check_eq("b995_delay", 64'(delay), 64'h1234);

    // Relock after a bad edge needs three good periods; new delay taken.
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("relock_state", 64'(state), 64'd2);
    check_eq("relock_delay", 64'(delay), 64'h5678);

    pps_rise(1005, EVT_ERR);
    check_at(last_rise + 4);
    check_eq("b1005_state", 64'(state), 64'd1);
    pps_rise(996, 2'd0);
    pps_rise(1004, 2'd0);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("acq_bounds_state", 64'(state), 64'd2);

    // One long period of 1010 while locked.
    pps_rise(1010, EVT_ERR);
    check_at(last_rise + 4);
    check_eq("p1010_state", 64'(state), 64'd1);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("p1010_relock", 64'(state), 64'd2);

    // Holdover entry, then an edge 998 cycles after the virtual edge.
    e = last_rise + 3;
    pps_low();
    check_at(e + 1005);
    check_eq("hold_pre_state", 64'(state), 64'd2);
    check_at(e + 1006);
    check_eq("hold_state",  64'(state),       64'd3);
    check_eq("hold_syncen", 64'(sync_enable), 64'd1);
    pps_rise(1998, 2'd0);
    check_at(last_rise + 4);
    check_eq("hold_back_state",  64'(state),      64'd2);
    check_eq("hold_back_period", 64'(pps_period), 64'd998);

    // Holdover expiry at the second overrun.
    e = last_rise + 3;
    pps_low();
    exp_q.push_back({EVT_ERR, 32'(e + 2005)});
    check_at(e + 1006);
    check_eq("exp_hold_state", 64'(state), 64'd3);
    check_at(e + 2005);
    check_eq("exp_pre_state",  64'(state),       64'd3);
    check_eq("exp_pre_syncen", 64'(sync_enable), 64'd1);
    check_at(e + 2006);
    check_eq("exp_state",  64'(state),       64'd1);
    check_eq("exp_syncen", 64'(sync_enable), 64'd0);

    // enable dropped in the cycle of the locking edge.
    pps_rise_at(cyc + 20, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    wait_cyc(last_rise + 3);
    enable = 1'b0;
    check_at(last_rise + 4);
    check_eq("dis_state",  64'(state),       64'd0);
    check_eq("dis_syncen", 64'(sync_enable), 64'd0);
    enable = 1'b1;

    // Lock again, then reset while locked.
    pps_low();
    pps_rise_at(cyc + 20, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("prerst_state", 64'(state), 64'd2);
    pps_low();
    wait_cyc(cyc + 5);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    wait_cyc(cyc + 3);
    rst_n = 1'b1;
    check_at(cyc + 2);
    check_eq("postrst_state", 64'(state), 64'd1);

    // Full reacquisition required after reset.
    pps_rise_at(cyc + 20, 2'd0);
    pps_rise(1000, 2'd0);
    pps_rise(1000, 2'd0);
    check_at(last_rise + 4);
    check_eq("reacq_partial", 64'(state), 64'd1);
    pps_rise(1000, EVT_SS);
    check_at(last_rise + 4);
    check_eq("reacq_state", 64'(state), 64'd2);
    check_eq("reacq_delay", 64'(delay), 64'h5678);

    // ---------------- report ----------------
    pps_low();
    repeat (10) @(posedge clk);
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pps_sync_ctrl.md
PPS_SYNC_CTRL -- requirements
Module: pps_sync_ctrl

Interface
REQ-001 SHALL have parameter FREQ, default 30720000, meaning clk cycles per nominal PPS period.
REQ-002 SHALL have parameter PPS_TOL, default 64, meaning max allowed |measured period - FREQ| in cycles.
REQ-003 SHALL have parameter LOCK_CNT, default 3, meaning consecutive good periods required to lock.
REQ-004 SHALL have parameter HOLD_MAX, default 4, meaning missed PPS periods tolerated in holdover.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst_n  input  1  reset; rst_n is asynchronous, active-low; clock is clk.
REQ-007 SHALL have port pps_in  input  1  asynchronous 1PPS from GNSS/PTP.
REQ-008 SHALL have port enable  input  1  level; 0 forces IDLE.
REQ-009 SHALL have port delay_cfg  input  32  PPS-to-frame offset in cycles.
REQ-010 SHALL have port sync_start  output  1  one-cycle pulse to the frame-sync counter block.
REQ-011 SHALL have port delay  output  32  delay_cfg latched at lock.
REQ-012 SHALL have port sync_enable  output  1  high in LOCKED or HOLDOVER.
REQ-013 SHALL have port pps_period  output  32  last measured edge-to-edge period.
REQ-014 SHALL have port pps_err  output  1  one-cycle pulse on bad period or holdover expiry.
REQ-015 SHALL have port state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3.

Function
REQ-016 SHALL pass pps_in through a 2-flop synchronizer plus edge register; pps_edge is asserted 3 cycles after the pps_in rise, for 1 cycle.
REQ-017 SHALL keep period_cnt (32 b), +1 per cycle, saturating at 2^32-1; on pps_edge pps_period <= period_cnt and period_cnt <= 1.
REQ-018 A period SHALL be good iff FREQ-PPS_TOL <= period_cnt <= FREQ+PPS_TOL at the edge.
REQ-019 IDLE: period_cnt, good_cnt and miss_cnt held at 0; enable=1 -> ACQUIRE with first_seen=0.
REQ-020 ACQUIRE: the first edge sets first_seen only; a later good edge increments good_cnt; a bad edge clears good_cnt and pulses pps_err.
REQ-021 ACQUIRE: period_cnt > FREQ+PPS_TOL without an edge clears good_cnt and first_seen.
REQ-022 ACQUIRE -> LOCKED on the edge where good_cnt reaches LOCK_CNT; on that same cycle sync_start=1 and delay<=delay_cfg.
REQ-023 LOCKED: a good edge stays; a bad edge pulses pps_err and goes to ACQUIRE with good_cnt=0 and first_seen=1.
REQ-024 LOCKED: period_cnt reaching FREQ+PPS_TOL+1 with no edge goes to HOLDOVER with miss_cnt=1 and period_cnt <= period_cnt-FREQ+1, i.e. flywheel rebased to a virtual edge.
REQ-025 HOLDOVER: each further overrun increments miss_cnt and rebases the flywheel; when miss_cnt reaches HOLD_MAX, pulse pps_err and go to ACQUIRE with first_seen=0.
REQ-026 HOLDOVER: a good edge returns to LOCKED with miss_cnt=0 and no sync_start; a bad edge pulses pps_err and goes to ACQUIRE.
REQ-027 enable=0 SHALL force IDLE on the next cycle from any state; this overrides a simultaneous edge, and sync_start/pps_err are not raised that cycle.
REQ-028 sync_start SHALL pulse only on ACQUIRE->LOCKED; delay and pps_period SHALL hold between updates.
REQ-029 A change to delay_cfg while locked SHALL have no effect until the next lock.

Reset
REQ-030 While rst_n=0: state=IDLE, and sync_start, sync_enable, pps_err, delay, pps_period, all counters and synchronizer flops SHALL be 0.
REQ-031 Reset mid-operation SHALL abort immediately; after release, lock requires a full reacquisition.

Structure
REQ-032 State encoding and the default FREQ/PPS_TOL values SHALL live in the shared facc_5g sync package.
REQ-033 The synchronizer plus edge detect SHALL be the single sub-module pps_edge_det.

Verification (FREQ=1000, PPS_TOL=4, LOCK_CNT=3, HOLD_MAX=2)
REQ-034 Edges every 1000 cycles, enable=1 -> sync_start pulses once, on the 4th edge detection, 3 cycles after the pps_in rise; delay=delay_cfg; state=2.
REQ-035 Locked, one period of 1010 -> pps_err pulse, state=1; sync_start reasserts after 3 further good periods.
REQ-036 Locked, edges stop -> state=3 at period_cnt=1005; pps_err and state=1 at the 2nd overrun; sync_enable falls with it.
REQ-037 Holdover, an edge arrives 998 cycles after the virtual edge -> state=2, no sync_start.
REQ-038 Periods of 996 and 1004 (boundaries) -> good; 995 and 1005 -> bad.
REQ-039 enable deasserted on the same cycle as the locking edge -> state=0, no sync_start; rst_n pulsed while locked -> all outputs 0.
